// File: rtl/riscv_mmio_pkg.sv
// Shared address map, STATUS layout and address decoder for the data-side
// MMIO responder.
package riscv_mmio_pkg;

   localparam logic [31:0] MMIO_TXDATA = 32'h8000_0000;
   localparam logic [31:0] MMIO_STATUS = 32'h8000_0004;
   localparam logic [31:0] MMIO_CYCLE  = 32'h8000_0008;
   localparam logic [31:0] MMIO_DONE   = 32'h8000_000C;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_TX,
      REG_STATUS,
      REG_CYCLE,
      REG_DONE,
      REG_NONE
   } region_e;

   // Byte lane bits are ignored, so the whole word shares one decode.
   function automatic region_e decode(input logic [31:0] addr,
                                      input logic [31:0] ram_bytes);
      logic [31:0] word_addr;
      word_addr = addr & 32'hFFFF_FFFC;
      if (word_addr < ram_bytes) return REG_RAM;
      case (word_addr)
         MMIO_TXDATA: return REG_TX;
         MMIO_STATUS: return REG_STATUS;
         MMIO_CYCLE:  return REG_CYCLE;
         MMIO_DONE:   return REG_DONE;
         default:     return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide show-ahead console FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same edge frees the slot a full-FIFO push needs.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
         if (push && !do_push) ovf <= 1'b1;
      end
   end

   // NOTE: storage is deliberately left out of reset; pointers alone define
   // which entries are valid, and head is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder: word RAM plus console FIFO, cycle counter, done
// register and sticky bus error, all on the core's single-cycle data port.
module dmem_mmio #(
   parameter int RAM_WORDS  = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic        we,
   output logic [31:0] out,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        done,
   output logic [31:0] done_code,
   output logic        bus_err
);
   import riscv_mmio_pkg::*;

   localparam int          RAM_AW    = $clog2(RAM_WORDS);
   localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

   region_e           region;
   logic [RAM_AW-1:0] ram_idx;
   logic [31:0]       ram [RAM_WORDS];
   logic [31:0]       cycle;
   logic [31:0]       status;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_ovf;
   logic [CNT_W-1:0]  fifo_count;

   assign region   = decode(addr, RAM_BYTES);
   assign ram_idx  = addr[RAM_AW+1:2];
   assign tx_valid = !fifo_empty;

   tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (we && (region == REG_TX)),
      .push_data (data[7:0]),
      .pop       (tx_ready),
      .head      (tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .ovf       (fifo_ovf)
   );

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      status                  = '0;
      status[ST_FULL]         = fifo_full;
      status[ST_EMPTY]        = fifo_empty;
      status[ST_OVF]          = fifo_ovf;
      status[ST_CNT_LSB +: 8] = 8'(fifo_count);

      out = '0;
      case (region)
         REG_RAM:    out = ram[ram_idx];
         REG_STATUS: out = status;
         REG_CYCLE:  out = cycle;
         REG_DONE:   out = done_code;
         default:    out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle     <= '0;
         done      <= 1'b0;
         done_code <= '0;
         bus_err   <= 1'b0;
      end else begin
         cycle <= (we && (region == REG_CYCLE)) ? data : cycle + 32'd1;
         if (we && (region == REG_DONE)) begin
            done      <= 1'b1;
            done_code <= data;
         end
         // Reads are checked every edge, so an unmapped address flags
         // whether or not the core is storing.
         if (region == REG_NONE) bus_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we && (region == REG_RAM)) ram[ram_idx] <= data;
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: register reads checked against constants,
// console bytes checked against a scoreboard queue as they drain.
module tb_dmem_mmio;
   import riscv_mmio_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] data = '0;
   logic        we = 1'b0;
   logic        tx_ready = 1'b0;
   logic [31:0] out;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        done;
   logic [31:0] done_code;
   logic        bus_err;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_b;

   dmem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data      (data),
      .we        (we),
      .out       (out),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .done      (done),
      .done_code (done_code),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      data = d;
      we   = 1'b1;
      @(posedge clk);
      #1;
      we   = 1'b0;
      addr = '0;
      data = '0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, out, exp);
      addr = '0;
   endtask

   // Scoreboard model: a byte is expected out only if the FIFO had room.
   task automatic push_byte(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      wr(MMIO_TXDATA, {24'h0, b});
   endtask

   task automatic drain(input string tag, input int n);
      tx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         check({tag, "_valid"}, {31'h0, tx_valid}, 32'h1);
         check({tag, "_data"}, {24'h0, tx_data}, {24'h0, exp_b});
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_bus_err", {31'h0, bus_err}, 32'h0);
      rst = 1'b1;
      rd("cycle_at_release", MMIO_CYCLE, 32'h0);
      rd("status_reset", MMIO_STATUS, 32'h0000_0002);
      @(posedge clk);
      #1;
      rd("cycle_first_edge", MMIO_CYCLE, 32'h1);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) push_byte(8'h50 + 8'(i));
      rd("status_full", MMIO_STATUS, 32'h0000_0801);
      addr     = MMIO_TXDATA;
      data     = 32'h5A;
      we       = 1'b1;
      tx_ready = 1'b1;
      #1;
      exp_b = exp_q.pop_front();
      check("pp_head", {24'h0, tx_data}, {24'h0, exp_b});
      exp_q.push_back(8'h5A);
      @(posedge clk);
      #1;
      we       = 1'b0;
      tx_ready = 1'b0;
      addr     = '0;
      rd("status_after_pp", MMIO_STATUS, 32'h0000_0801);
      drain("pp_drain", DEPTH);
      check("pp_empty_valid", {31'h0, tx_valid}, 32'h0);
      rd("status_pp_empty", MMIO_STATUS, 32'h0000_0002);

      // Overflow: nine pushes into eight entries
      for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i));
      rd("status_ovf", MMIO_STATUS, 32'h0000_0805);
      drain("ovf_drain", DEPTH);
      check("ovf_empty_valid", {31'h0, tx_valid}, 32'h0);
      rd("status_ovf_empty", MMIO_STATUS, 32'h0000_0006);
      rd("txdata_read", MMIO_TXDATA, 32'h0);

      // RAM, boundaries and read-during-write
      wr(32'h14, 32'h1234_5678);
      wr(32'h10, 32'hDEAD_BEEF);
      rd("ram_0x13", 32'h13, 32'hDEAD_BEEF);
      rd("ram_0x14", 32'h14, 32'h1234_5678);
      wr(32'h3FC, 32'hA5A5_A5A5);
      rd("ram_top", 32'h3FF, 32'hA5A5_A5A5);
      addr = 32'h10;
      data = 32'hCAFE_F00D;
      we   = 1'b1;
      #1;
      check("rdw_old", out, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      we = 1'b0;
      check("rdw_new", out, 32'hCAFE_F00D);
      addr = '0;
      wr(MMIO_STATUS, 32'hFFFF_FFFF);
      rd("status_ro", MMIO_STATUS, 32'h0000_0006);
      check("ro_no_bus_err", {31'h0, bus_err}, 32'h0);
      wr(32'h4000_0000, 32'h1);
      check("bus_err_set", {31'h0, bus_err}, 32'h1);
      rd("unmapped_read", 32'h4000_0000, 32'h0);
      rd("ram_end_plus", 32'h400, 32'h0);

      // Counter load and wrap
      wr(MMIO_CYCLE, 32'hFFFF_FFFE);
      rd("cycle_load", MMIO_CYCLE, 32'hFFFF_FFFE);
      @(posedge clk);
      #1;
      rd("cycle_plus1", MMIO_CYCLE, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      rd("cycle_wrap", MMIO_CYCLE, 32'h0);
      @(posedge clk);
      #1;
      rd("cycle_after_wrap", MMIO_CYCLE, 32'h1);

      // Done register, then reset mid-run
      check("done_idle", {31'h0, done}, 32'h0);
      wr(MMIO_DONE, 32'h1);
      check("done_set", {31'h0, done}, 32'h1);
      check("done_code_1", done_code, 32'h1);
      wr(MMIO_DONE, 32'h7);
      check("done_code_7", done_code, 32'h7);
      rd("done_read", MMIO_DONE, 32'h7);
      for (int i = 0; i < 3; i++) push_byte(8'h61 + 8'(i));
      check("queued_valid", {31'h0, tx_valid}, 32'h1);
      rd("status_queued", MMIO_STATUS, 32'h0000_0304);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_done", {31'h0, done}, 32'h0);
      check("midrst_done_code", done_code, 32'h0);
      check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("midrst_bus_err", {31'h0, bus_err}, 32'h0);
      rd("midrst_status", MMIO_STATUS, 32'h0000_0002);
      rd("midrst_cycle", MMIO_CYCLE, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rd("rerelease_cycle", MMIO_CYCLE, 32'h1);
      check("rerelease_valid", {31'h0, tx_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
